// File: rtl/fpga_template_pkg.sv
// Shared types and default sizing for the frame peak detector.
package fpga_template_pkg;

  localparam int unsigned DEFAULT_WIDTH = 36;
  localparam int unsigned DEFAULT_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REPORT
  } peak_state_t;

endpackage

// File: rtl/frame_peak_detector.sv
// Per-frame peak |sample|, its first index and the sum of |sample|, with a
// held result handshake and restart/pending handling for frame starts.
module frame_peak_detector
  import fpga_template_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       frame_start_i,
  input  logic [WIDTH-1:0]           sample_data_i,
  input  logic                       sample_valid_i,
  output logic                       sample_ready_o,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [WIDTH-1:0]           peak_mag_o,
  output logic [IDX_WIDTH-1:0]       peak_idx_o,
  output logic [WIDTH+IDX_WIDTH-1:0] sum_abs_o,
  output logic                       frame_error_o,
  output logic [7:0]                 frame_count_o
);

  localparam int unsigned SUM_W = WIDTH + IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

  peak_state_t          state;
  logic                 pending;
  logic [IDX_WIDTH-1:0] cnt;
  logic [IDX_WIDTH-1:0] run_idx;
  logic [WIDTH-1:0]     run_peak;
  logic [SUM_W-1:0]     run_sum;

  logic [WIDTH-1:0]     abs_c;
  logic                 accept_c;
  logic                 last_c;
  logic [WIDTH-1:0]     nxt_peak_c;
  logic [IDX_WIDTH-1:0] nxt_idx_c;
  logic [SUM_W-1:0]     nxt_sum_c;

  // Unsigned magnitude; the most-negative input wraps to exactly 2^(WIDTH-1).
  always_comb begin
    abs_c      = sample_data_i[WIDTH-1] ? (~sample_data_i + WIDTH'(1)) : sample_data_i;
    accept_c   = sample_valid_i && sample_ready_o;
    last_c     = accept_c && (cnt == LAST_IDX);
    nxt_peak_c = run_peak;
    nxt_idx_c  = run_idx;
    if (abs_c > run_peak) begin
      nxt_peak_c = abs_c;
      nxt_idx_c  = cnt;
    end
    nxt_sum_c  = run_sum + SUM_W'(abs_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      pending        <= 1'b0;
      cnt            <= '0;
      run_idx        <= '0;
      run_peak       <= '0;
      run_sum        <= '0;
      sample_ready_o <= 1'b0;
      result_valid_o <= 1'b0;
      peak_mag_o     <= '0;
      peak_idx_o     <= '0;
      sum_abs_o      <= '0;
      frame_error_o  <= 1'b0;
      frame_count_o  <= '0;
    end else begin
      frame_error_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start_i) begin
            cnt            <= '0;
            run_idx        <= '0;
            run_peak       <= '0;
            run_sum        <= '0;
            pending        <= 1'b0;
            sample_ready_o <= 1'b1;
            state          <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (frame_start_i && !last_c) begin
            // Early restart: drop partial frame and any sample accepted now.
            cnt           <= '0;
            run_idx       <= '0;
            run_peak      <= '0;
            run_sum       <= '0;
            frame_error_o <= 1'b1;
          end else if (last_c) begin
            peak_mag_o     <= nxt_peak_c;
            peak_idx_o     <= nxt_idx_c;
            sum_abs_o      <= nxt_sum_c;
            result_valid_o <= 1'b1;
            sample_ready_o <= 1'b0;
            frame_count_o  <= frame_count_o + 8'd1;
            pending        <= frame_start_i;
            state          <= ST_REPORT;
          end else if (accept_c) begin
            run_peak <= nxt_peak_c;
            run_idx  <= nxt_idx_c;
            run_sum  <= nxt_sum_c;
            cnt      <= cnt + IDX_WIDTH'(1);
          end
        end
        ST_REPORT: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            if (pending || frame_start_i) begin
              cnt            <= '0;
              run_idx        <= '0;
              run_peak       <= '0;
              run_sum        <= '0;
              pending        <= 1'b0;
              sample_ready_o <= 1'b1;
              state          <= ST_COLLECT;
            end else begin
              state <= ST_IDLE;
            end
          end else if (frame_start_i) begin
            pending <= 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          sample_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_peak_detector.md
FRAME_PEAK_DETECTOR -- requirements
Module: frame_peak_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 36, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 256, samples per frame.
REQ-003 SHALL have parameter IDX_WIDTH, default $clog2(DEPTH), sample index width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port frame_start_i  input  1  one-cycle pulse: a full frame is available upstream.
REQ-007 SHALL have port sample_data_i  input  WIDTH  signed frame sample.
REQ-008 SHALL have port sample_valid_i  input  1  sample_data_i valid.
REQ-009 SHALL have port sample_ready_o  output  1  detector accepts a sample this cycle.
REQ-010 SHALL have port result_valid_o  output  1  frame result held on result outputs.
REQ-011 SHALL have port result_ready_i  input  1  consumer takes the result.
REQ-012 SHALL have port peak_mag_o  output  WIDTH  unsigned largest |sample| in the frame.
REQ-013 SHALL have port peak_idx_o  output  IDX_WIDTH  index of the first sample reaching peak_mag_o.
REQ-014 SHALL have port sum_abs_o  output  WIDTH+IDX_WIDTH  sum of |sample| over the frame.
REQ-015 SHALL have port frame_error_o  output  1  one-cycle pulse: frame restarted before completion.
REQ-016 SHALL have port frame_count_o  output  8  completed frames, wraps 255->0.

Function
REQ-017 SHALL use a three-state FSM: IDLE, COLLECT, REPORT.
REQ-018 sample_ready_o SHALL be 1 only in COLLECT; accept = sample_valid_i && sample_ready_o.
REQ-019 IDLE: on frame_start_i -> COLLECT next cycle; clear sample counter, running peak, running index, running sum.
REQ-020 |x| SHALL be computed at WIDTH bits unsigned; most-negative input yields 2^(WIDTH-1) exactly, no saturation.
REQ-021 On each accept, running peak/index SHALL update only if |x| > running peak (strict; first occurrence wins, ties keep earlier index).
REQ-022 On each accept, running sum SHALL add |x| without overflow (width covers DEPTH * 2^(WIDTH-1)); sample counter increments.
REQ-023 Accept of sample index DEPTH-1 SHALL register final peak, index, sum onto outputs, set result_valid_o next cycle, enter REPORT, increment frame_count_o.
REQ-024 Result outputs SHALL be stable while result_valid_o=1 and update only at REQ-023.
REQ-025 REPORT: result_valid_o held until result_ready_i=1; that cycle clears result_valid_o; next state IDLE, or COLLECT if a frame start is pending.
REQ-026 frame_start_i in COLLECT (not on the final accept): restart frame (clear running values, counter to 0), pulse frame_error_o next cycle; the sample accepted that cycle is discarded.
REQ-027 frame_start_i in REPORT, or coincident with the final accept, SHALL set a pending flag; pending cleared on entry to COLLECT; no frame_error_o.
REQ-028 Latency: last sample accept edge to result_valid_o = 1 cycle; result handshake to sample_ready_o = 1 cycle when pending.
REQ-029 sample_valid_i while sample_ready_o=0 SHALL be ignored; no internal state change.

Reset
REQ-030 While rst_i=1 at a clock edge: state IDLE, pending 0, counter 0, sample_ready_o 0, result_valid_o 0, peak_mag_o 0, peak_idx_o 0, sum_abs_o 0, frame_error_o 0, frame_count_o 0.
REQ-031 Reset mid-frame or mid-REPORT SHALL discard partial/held results; no result_valid_o after reset until a new full frame.

Structure
REQ-032 State typedef peak_state_t and default WIDTH/DEPTH constants SHALL live in fpga_template_pkg.
REQ-033 Single module; no sub-module (abs and compare inline).

Verification
REQ-034 Frame of 256 samples, value i-128 at index i -> peak_mag_o=128, peak_idx_o=0, sum_abs_o=16384, frame_count_o=1.
REQ-035 Frame all zero except index 17=+5 and index 200=-5 -> peak_mag_o=5, peak_idx_o=17, sum_abs_o=10.
REQ-036 Sample index 3 = -2^35, others 0 -> peak_mag_o=2^35, peak_idx_o=3, sum_abs_o=2^35.
REQ-037 frame_start_i after 100 accepts, then full frame of all 7 -> frame_error_o one pulse, peak_mag_o=7, sum_abs_o=1792, frame_count_o=1.
REQ-038 result_ready_i held 0 for 20 cycles with frame_start_i pulsed in REPORT -> outputs stable 20 cycles, sample_ready_o=1 one cycle after handshake.
REQ-039 rst_i asserted after 50 accepts -> all outputs 0 next cycle; sample_valid_i then ignored until frame_start_i.
